rpm_meter_multi: RTL

Multi-channel, parametrised pulse-rate meter for ignition/tach pulses. Each channel synchronises an asynchronous pulse input, detects rising edges in the clk domain, and counts them over a programmable gate window. At each window end all channels latch their counts together and a one-cycle valid strobe is issued. It feeds the display/formatting logic of the moto display as the successor to the single-channel 8-bit RPM counter, with saturation, overflow flags and run/stop control added.

---
 rtl/rpm_meter_multi.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rpm_meter_multi.sv
// Multi-channel pulse-rate meter: per-channel synchroniser, edge counter and gated latch.
// Optional `RPM_SCALE_EN multiplies each latched count by SCALE (registered, +1 latency).
module rpm_meter_multi #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CW          = 16,
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned TW          = 26,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SCALE       = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      pulse_in,
  input  logic                enable,
  output logic [NCH*CW-1:0]   data_rpm,
  output logic                data_valid,
  output logic [NCH-1:0]      overflow,
  output logic                busy
);

  localparam logic [TW-1:0] TERM    = TW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit PARAMS_OK = (NCH >= 1) && (NCH <= 8) && (GATE_CYCLES >= 4) &&
                             (SYNC_STAGES >= 2) && (SCALE >= 1) && (CW >= 1) &&
                             ((64'(GATE_CYCLES) - 64'd1) < (64'd1 << TW));

  if (!PARAMS_OK) begin : g_param_check
    $error("rpm_meter_multi: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_LATCH} state_e;

  state_e                        state_q, state_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                prev_q;
  logic [NCH-1:0]                rise_c;
  logic [NCH-1:0][CW-1:0]        cnt_q, cnt_d;
  logic [NCH-1:0]                sat_q, sat_d;
  logic [NCH-1:0][CW-1:0]        data_q, data_d;
  logic [NCH-1:0]                ovf_q, ovf_d;
  logic                          valid_q, valid_d;
  logic                          busy_q;

  // Synchroniser chain followed by the previous-value register for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Gate FSM, window timer and saturating per-channel counters
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        cnt_d   = '0;
        sat_d   = '0;
        if (enable) state_d = S_GATE;
      end
      S_GATE: begin
        if (!enable) begin
          state_d = S_IDLE;
          timer_d = '0;
          cnt_d   = '0;
          sat_d   = '0;
        end else begin
          for (int k = 0; k < NCH; k++) begin
            if (rise_c[k]) begin
              if (cnt_q[k] == CNT_MAX) sat_d[k] = 1'b1;
              else                     cnt_d[k] = cnt_q[k] + CW'(1);
            end
          end
          if (timer_q == TERM) begin
            state_d = S_LATCH;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_LATCH: begin
        // An edge arriving here is the first edge of the next window
        timer_d = '0;
        sat_d   = '0;
        for (int k = 0; k < NCH; k++) cnt_d[k] = CW'(rise_c[k]);
        state_d = enable ? S_GATE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RPM_SCALE_EN
  localparam int unsigned SW = $clog2(SCALE + 1);
  localparam int unsigned PW = CW + SW;

  logic [NCH-1:0][CW-1:0] lat_cnt_q;
  logic [NCH-1:0]         lat_sat_q;
  logic                   lat_vld_q;
  logic [NCH-1:0][PW-1:0] prod_c;

  // Capture the closing window so the multiply has a full cycle of its own
  always_ff @(posedge clk) begin
    if (!reset) begin
      lat_cnt_q <= '0;
      lat_sat_q <= '0;
      lat_vld_q <= 1'b0;
    end else begin
      lat_vld_q <= (state_q == S_LATCH);
      if (state_q == S_LATCH) begin
        lat_cnt_q <= cnt_q;
        lat_sat_q <= sat_q;
      end
    end
  end

  always_comb begin
    prod_c  = '0;
    data_d  = data_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    for (int k = 0; k < NCH; k++) prod_c[k] = PW'(lat_cnt_q[k]) * PW'(SCALE);
    if (lat_vld_q) begin
      valid_d = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        if (prod_c[k] > PW'(CNT_MAX)) begin
          data_d[k] = CNT_MAX;
          ovf_d[k]  = 1'b1;
        end else begin
          data_d[k] = prod_c[k][CW-1:0];
          ovf_d[k]  = lat_sat_q[k];
        end
      end
    end
  end
`else
  always_comb begin
    data_d  = data_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (state_q == S_LATCH) begin
      data_d  = cnt_q;
      ovf_d   = sat_q;
      valid_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sat_q   <= '0;
      data_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign data_rpm   = data_q;
  assign overflow   = ovf_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;

endmodule
